// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared types for the sequential arithmetic engine and its control unit:
//   op_e    - operation select (ADD, SUB, MUL, DIV)
//   state_e - engine sequencing states (IDLE, RUN, FIX, DONE)
// -----------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_arith_engine_muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of either a radix-2 shift-add multiply or a
// restoring divide, operating on unsigned magnitudes.
// Ports:
//   is_div    in   1         1: restoring-divide step, 0: shift-add step
//   acc       in   2*WIDTH   MUL: partial product; DIV: partial remainder (low WIDTH+1 bits)
//   mcand     in   2*WIDTH   MUL: multiplicand shifted left by iterations done;
//                            DIV: divisor in the low WIDTH bits (never shifted)
//   q         in   WIDTH     MUL: remaining multiplier; DIV: dividend shifting out / quotient shifting in
//   acc_nx, mcand_nx, q_nx   out  next values of the above
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 8
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [2*WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]     q,
    output logic [2*WIDTH-1:0]   acc_nx,
    output logic [2*WIDTH-1:0]   mcand_nx,
    output logic [WIDTH-1:0]     q_nx
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] trial_s;

    // Single iteration: shift-add for MUL, trial subtract and restore for DIV
    always_comb begin
        // Bring the next dividend bit into the partial remainder, then try subtracting.
        shifted_s = {acc[WIDTH-1:0], q[WIDTH-1]};
        trial_s   = {1'b0, shifted_s} - {2'b00, mcand[WIDTH-1:0]};
        if (is_div) begin
            mcand_nx = mcand;
            if (trial_s[WIDTH+1]) begin
                // Borrow: divisor did not fit, keep the shifted remainder.
                acc_nx = {{(WIDTH-1){1'b0}}, shifted_s};
                q_nx   = {q[WIDTH-2:0], 1'b0};
            end else begin
                acc_nx = {{(WIDTH-1){1'b0}}, trial_s[WIDTH:0]};
                q_nx   = {q[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (q[0]) begin
                acc_nx = acc + mcand;
            end else begin
                acc_nx = acc;
            end
            mcand_nx = {mcand[2*WIDTH-2:0], 1'b0};
            q_nx     = {1'b0, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_arith_engine.sv
// -----------------------------------------------------------------------------
// seq_arith_engine
// Start/done four-function arithmetic engine (add/sub/mul/div) with WIDTH-bit
// operands, signed or unsigned per operation. ADD/SUB and divide-by-zero finish
// in one cycle; MUL/DIV iterate WIDTH times then apply a sign fix-up.
// Optional build macro: MUL_EARLY_TERM_EN - MUL leaves the iteration phase as
// soon as the remaining multiplier magnitude is zero (after at least one step).
// Ports:
//   clock        in   1        system clock, rising edge
//   reset        in   1        asynchronous, active-low
//   clear        in   1        synchronous abort back to IDLE, no done
//   start        in   1        operation request, sampled only in IDLE
//   op           in   op_e     ADD / SUB / MUL / DIV
//   is_signed    in   1        operands are two's complement
//   a, b         in   WIDTH    operands (a = dividend / multiplicand)
//   busy         out  1        engine not idle
//   done         out  1        one-cycle pulse, result and flags valid
//   result       out  2*WIDTH  ADD/SUB: extended sum; MUL: product; DIV: {quotient, remainder}
//   zero, ovr    out  1        condition codes, held between operations
//   div_by_zero  out  1        DIV with b == 0
// -----------------------------------------------------------------------------
module seq_arith_engine
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 start,
    input  op_e                  op,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero,
    output logic                 ovr,
    output logic                 div_by_zero
);

    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LAST_ITER = WIDTH'(WIDTH - 1);

    // Two's-complement magnitude of an operand when signed, otherwise unchanged.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        logic [WIDTH-1:0] m;
        if (sgn && x[WIDTH-1]) begin
            m = -x;
        end else begin
            m = x;
        end
        return m;
    endfunction

    state_e               state_r, next_state_s;
    op_e                  op_r;
    logic                 signed_r, neg_r, aneg_r;
    logic [WIDTH-1:0]     q_r, cnt_r;
    logic [2*WIDTH-1:0]   acc_r, mcand_r;
    logic [2*WIDTH-1:0]   acc_nx_s, mcand_nx_s;
    logic [WIDTH-1:0]     q_nx_s;
    logic                 accept_s, step_s, fix_s, quick_s, run_last_s;

    logic [WIDTH:0]       arith_s;
    logic                 sovf_s;
    logic [2*WIDTH-1:0]   quick_result_s, fix_result_s, prod_s;
    logic                 quick_zero_s, quick_ovr_s, quick_dbz_s;
    logic                 fix_zero_s, fix_ovr_s;
    logic [WIDTH-1:0]     quot_s, rem_s;

    logic                 busy_r, done_r, zero_r, ovr_r, dbz_r;
    logic [2*WIDTH-1:0]   result_r;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_r == OP_DIV),
        .acc      (acc_r),
        .mcand    (mcand_r),
        .q        (q_r),
        .acc_nx   (acc_nx_s),
        .mcand_nx (mcand_nx_s),
        .q_nx     (q_nx_s)
    );

`ifdef MUL_EARLY_TERM_EN
    // Multiplication can stop once no multiplier bits remain to be consumed.
    assign run_last_s = (cnt_r == LAST_ITER) ||
                        ((op_r == OP_MUL) && (q_nx_s == {WIDTH{1'b0}}));
`else
    assign run_last_s = (cnt_r == LAST_ITER);
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-state control strobes; clear overrides everything
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        fix_s        = 1'b0;
        quick_s      = 1'b0;
        if (clear) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        accept_s = 1'b1;
                        if ((op == OP_ADD) || (op == OP_SUB) ||
                            ((op == OP_DIV) && (b == {WIDTH{1'b0}}))) begin
                            quick_s      = 1'b1;
                            next_state_s = DONE;
                        end else begin
                            next_state_s = RUN;
                        end
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                RUN: begin
                    step_s = 1'b1;
                    if (run_last_s) begin
                        next_state_s = FIX;
                    end else begin
                        next_state_s = RUN;
                    end
                end
                FIX: begin
                    fix_s        = 1'b1;
                    next_state_s = DONE;
                end
                DONE: begin
                    next_state_s = IDLE;
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // Single-cycle results: ADD/SUB straight from the inputs, and divide by zero
    always_comb begin
        arith_s = {1'b0, a} + {1'b0, b};
        sovf_s  = 1'b0;
        case (op)
            OP_ADD: begin
                arith_s = {1'b0, a} + {1'b0, b};
                sovf_s  = (a[WIDTH-1] == b[WIDTH-1]) && (arith_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the difference is the unsigned borrow.
                arith_s = {1'b0, a} - {1'b0, b};
                sovf_s  = (a[WIDTH-1] != b[WIDTH-1]) && (arith_s[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                arith_s = {1'b0, a} + {1'b0, b};
                sovf_s  = 1'b0;
            end
        endcase
        if (op == OP_DIV) begin
            quick_result_s = {{WIDTH{1'b1}}, a};
            quick_zero_s   = 1'b0;
            quick_ovr_s    = 1'b0;
            quick_dbz_s    = 1'b1;
        end else begin
            if (is_signed) begin
                quick_result_s = {{WIDTH{arith_s[WIDTH-1]}}, arith_s[WIDTH-1:0]};
                quick_ovr_s    = sovf_s;
            end else begin
                quick_result_s = {{WIDTH{1'b0}}, arith_s[WIDTH-1:0]};
                quick_ovr_s    = arith_s[WIDTH];
            end
            quick_zero_s = (arith_s[WIDTH-1:0] == {WIDTH{1'b0}});
            quick_dbz_s  = 1'b0;
        end
    end

    // Sign fix-up of the iterated magnitudes and MUL/DIV condition codes
    always_comb begin
        if (neg_r) begin
            prod_s = -acc_r;
            quot_s = -q_r;
        end else begin
            prod_s = acc_r;
            quot_s = q_r;
        end
        if (aneg_r) begin
            rem_s = -acc_r[WIDTH-1:0];
        end else begin
            rem_s = acc_r[WIDTH-1:0];
        end
        if (op_r == OP_MUL) begin
            fix_result_s = prod_s;
            fix_zero_s   = (prod_s == {(2*WIDTH){1'b0}});
            if (signed_r) begin
                fix_ovr_s = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
            end else begin
                fix_ovr_s = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            end
        end else begin
            fix_result_s = {quot_s, rem_s};
            fix_zero_s   = (quot_s == {WIDTH{1'b0}});
            // Only MIN / -1 yields a positive quotient magnitude with the top bit set.
            fix_ovr_s    = signed_r && !neg_r && q_r[WIDTH-1];
        end
    end

    // Operand latch on start and iteration datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_r     <= OP_ADD;
            signed_r <= 1'b0;
            neg_r    <= 1'b0;
            aneg_r   <= 1'b0;
            q_r      <= {WIDTH{1'b0}};
            cnt_r    <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
        end else if (accept_s) begin
            op_r     <= op;
            signed_r <= is_signed;
            neg_r    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            aneg_r   <= is_signed && a[WIDTH-1];
            cnt_r    <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            if (op == OP_DIV) begin
                q_r     <= mag(a, is_signed);
                mcand_r <= {{WIDTH{1'b0}}, mag(b, is_signed)};
            end else begin
                q_r     <= mag(b, is_signed);
                mcand_r <= {{WIDTH{1'b0}}, mag(a, is_signed)};
            end
        end else if (step_s) begin
            acc_r   <= acc_nx_s;
            mcand_r <= mcand_nx_s;
            q_r     <= q_nx_s;
            if (cnt_r != {WIDTH{1'b1}}) begin
                cnt_r <= cnt_r + ONE_W;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    // Registered outputs: result and flags load only on the cycle done rises
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
            zero_r   <= 1'b0;
            ovr_r    <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            done_r <= quick_s || fix_s;
            if (quick_s) begin
                result_r <= quick_result_s;
                zero_r   <= quick_zero_s;
                ovr_r    <= quick_ovr_s;
                dbz_r    <= quick_dbz_s;
            end else if (fix_s) begin
                result_r <= fix_result_s;
                zero_r   <= fix_zero_s;
                ovr_r    <= fix_ovr_s;
                dbz_r    <= 1'b0;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign result      = result_r;
    assign zero        = zero_r;
    assign ovr         = ovr_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_arith_engine.sv
// -----------------------------------------------------------------------------
// tb_seq_arith_engine
// Scoreboard bench: each accepted operation pushes its expected result, flags
// and latency (computed with plain integer arithmetic) into a queue; a monitor
// pops and compares whenever done is seen. Directed corner cases are followed
// by clear/reset aborts and randomized operations.
// Honours MUL_EARLY_TERM_EN for the expected MUL latency.
// -----------------------------------------------------------------------------
module tb_seq_arith_engine;
    import arith_pkg::*;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic             start = 1'b0;
    op_e              op = OP_ADD;
    logic             is_signed = 1'b0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             busy, done, zero, ovr, div_by_zero;
    logic [2*W-1:0]   result;

    typedef struct {
        logic [2*W-1:0] result;
        logic           zero;
        logic           ovr;
        logic           dbz;
        int             lat;
        int             issue;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    logic [2*W-1:0] last_result = '0;
    int             cyc = 0;
    int             compared = 0;
    int             mismatched = 0;

    seq_arith_engine #(.WIDTH(W)) dut (
        .clock       (clk),
        .reset       (reset),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .ovr         (ovr),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: outcome of one operation from plain integer arithmetic.
    function automatic exp_t model(input op_e o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int ix, iy, r, q, rm, mb, k;
        logic [W-1:0] lo;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        e.zero = 1'b0; e.ovr = 1'b0; e.dbz = 1'b0; e.lat = 1; e.issue = 0;
        e.result = '0;
        case (o)
            OP_ADD, OP_SUB: begin
                r  = (o == OP_ADD) ? ix + iy : ix - iy;
                lo = W'(r);
                e.result = s ? {{W{lo[W-1]}}, lo} : {{W{1'b0}}, lo};
                e.zero   = (lo == '0);
                e.ovr    = s ? (r < -(1 << (W-1)) || r > (1 << (W-1)) - 1) : (r < 0 || r > (1 << W) - 1);
            end
            OP_MUL: begin
                r = ix * iy;
                e.result = (2*W)'(r);
                e.zero   = (r == 0);
                e.ovr    = s ? (r < -(1 << (W-1)) || r > (1 << (W-1)) - 1) : (r > (1 << W) - 1);
                e.lat    = W + 2;
`ifdef MUL_EARLY_TERM_EN
                mb = (iy < 0) ? -iy : iy;
                k = 0;
                while (mb > 0) begin
                    k++;
                    mb = mb >> 1;
                end
                if (k < 1) k = 1;
                e.lat = k + 2;
`endif
            end
            default: begin
                if (iy == 0) begin
                    e.result = {{W{1'b1}}, x};
                    e.dbz    = 1'b1;
                end else if (s && ix == -(1 << (W-1)) && iy == -1) begin
                    e.result = {1'b1, {(2*W-1){1'b0}}};
                    e.ovr    = 1'b1;
                    e.lat    = W + 2;
                end else begin
                    q  = ix / iy;
                    rm = ix % iy;
                    e.result = {W'(q), W'(rm)};
                    e.zero   = (q == 0);
                    e.lat    = W + 2;
                end
            end
        endcase
        return e;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            compared++;
            mismatched++;
            $display("FAIL idle_wait: busy got 1 expected 0");
        end
    endtask

    // Issue one operation; push the expectation only if it should complete.
    task automatic issue(input op_e o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        exp_t e;
        wait_idle();
        op = o; is_signed = s; a = x; b = y; start = 1'b1;
        if (push) begin
            e = model(o, s, x, y);
            e.issue = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard
    initial begin
        forever begin
            @(posedge clk); #1;
            if (done) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got done=1 result %0h expected no done", result);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", 32'(result), 32'(mon_e.result));
                    chk("zero", 32'(zero), 32'(mon_e.zero));
                    chk("ovr", 32'(ovr), 32'(mon_e.ovr));
                    chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
                    chk("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
                    last_result = mon_e.result;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [W-1:0] x, y;
        op_e o;
        logic s;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed corners
        issue(OP_ADD, 1'b0, 8'd200, 8'd100, 1'b1);
        issue(OP_MUL, 1'b1, 8'hF9, 8'd9, 1'b1);
        issue(OP_MUL, 1'b0, 8'd255, 8'd255, 1'b1);
        issue(OP_DIV, 1'b0, 8'd200, 8'd7, 1'b1);
        issue(OP_DIV, 1'b1, 8'h9C, 8'd7, 1'b1);
        issue(OP_DIV, 1'b1, 8'h80, 8'hFF, 1'b1);
        issue(OP_DIV, 1'b0, 8'h55, 8'h00, 1'b1);
        issue(OP_SUB, 1'b1, 8'h80, 8'h01, 1'b1);
        issue(OP_SUB, 1'b0, 8'd3, 8'd5, 1'b1);
        issue(OP_ADD, 1'b1, 8'h7F, 8'h01, 1'b1);
        issue(OP_MUL, 1'b1, 8'h80, 8'h80, 1'b1);
        issue(OP_MUL, 1'b0, 8'd5, 8'd2, 1'b1);
        issue(OP_MUL, 1'b0, 8'd5, 8'd0, 1'b1);
        wait_idle();

        // MUL aborted by clear in cycle 4; start in cycle 3 is ignored
        issue(OP_MUL, 1'b0, 8'd13, 8'd11, 1'b0);
        chk("busy_run", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        op = OP_ADD; a = 8'd1; b = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b1;
        chk("busy_before_clear", 32'(busy), 32'd1);
        @(posedge clk); #1;
        clear = 1'b0;
        chk("busy_after_clear", 32'(busy), 32'd0);
        repeat (12) begin
            @(posedge clk); #1;
        end
        chk("result_kept_clear", 32'(result), 32'(last_result));

        // clear and start together: clear wins
        op = OP_ADD; is_signed = 1'b0; a = 8'd9; b = 8'd9; start = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        chk("busy_clear_start", 32'(busy), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("result_kept_cs", 32'(result), 32'(last_result));

        // Asynchronous reset in the middle of a DIV
        issue(OP_DIV, 1'b0, 8'd100, 8'd3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        #2 reset = 1'b1;
        last_result = '0;
        @(posedge clk); #1;

        // Randomized operations
        for (int i = 0; i < 80; i++) begin
            o = op_e'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            x = W'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                x = 8'h80;
                y = 8'hFF;
            end
            issue(o, s, x, y, 1'b1);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
